demux1an_fifo: RTL

Parametrised 1-to-N demultiplexer with per-channel FIFO buffering, the next generation of the 1:2 valid/data demux. Each input word with `valid` high is steered by `selector` into one of `N_OUT` independent FIFOs of depth `DEPTH`. Downstream consumers drain their own channel with a per-channel `pop`. Full/empty flags and an error pulse report backpressure, overflow and bad selects. The block sits between the lane-splitting stage and the per-lane consumers.

---
 rtl/demux1an_fifo.sv | 109 ++++++++++
 1 files changed

// File: rtl/demux1an_fifo.sv
// 1-to-N valid/data demultiplexer with an independent FIFO per output channel.
// Words are steered by selector; each channel is drained by its own pop bit.
module demux1an_fifo #(
  parameter int DATA_W   = 8,
  parameter int N_OUT    = 2,
  parameter int SEL_W    = 1,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    valid,
  input  logic [SEL_W-1:0]        selector,
  input  logic [DATA_W-1:0]       data_in,
  input  logic [N_OUT-1:0]        pop,
  output logic [N_OUT-1:0]        validout,
  output logic [N_OUT*DATA_W-1:0] dataout,
  output logic [N_OUT-1:0]        empty,
  output logic [N_OUT-1:0]        full,
  output logic [N_OUT-1:0]        almost_full,
  output logic                    err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [N_OUT-1:0] wr_en;
  logic [N_OUT-1:0] pop_eff;
  logic             drop;

  // NOTE: combinational logic uses blocking assignments with a default for
  // every output first, so no latch is inferred and later lines see earlier ones.
  always_comb begin
    wr_en   = '0;
    pop_eff = pop & ~empty;
    for (int i = 0; i < N_OUT; i++) begin
      if (valid && (selector == SEL_W'(i)) && (!full[i] || pop_eff[i]))
        wr_en[i] = 1'b1;
    end
    // An out-of-range selector never matches a channel, so it lands here too.
    drop = valid && (wr_en == '0);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) err <= 1'b0;
    else          err <= drop;
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [DATA_W-1:0] data_q;
    logic              vo_q;
    logic              empty_q;
    logic              full_q;
    logic              af_q;

    // A simultaneous write and read leave occupancy unchanged.
    always_comb begin
      count_nxt = count;
      if (wr_en[g] && !pop_eff[g])
        count_nxt = count + CNT_W'(1);
      else if (!wr_en[g] && pop_eff[g])
        count_nxt = count - CNT_W'(1);
    end

    // NOTE: the storage array has no reset; the pointers and counter alone
    // decide what is valid, which keeps the array a plain RAM.
    always_ff @(posedge clk) begin
      if (wr_en[g]) mem[wr_ptr] <= data_in;
    end

    // NOTE: all state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        data_q  <= '0;
        vo_q    <= 1'b0;
        empty_q <= 1'b1;
        full_q  <= 1'b0;
        af_q    <= 1'b0;
      end else begin
        if (wr_en[g]) wr_ptr <= wr_ptr + PTR_W'(1);
        vo_q <= pop_eff[g];
        if (pop_eff[g]) begin
          data_q <= mem[rd_ptr];
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count   <= count_nxt;
        empty_q <= (count_nxt == '0);
        full_q  <= (count_nxt == CNT_W'(DEPTH));
        af_q    <= (count_nxt >= CNT_W'(AF_LEVEL));
      end
    end

    assign dataout[g*DATA_W +: DATA_W] = data_q;
    assign validout[g]    = vo_q;
    assign empty[g]       = empty_q;
    assign full[g]        = full_q;
    assign almost_full[g] = af_q;
  end

endmodule
